seq_nbit_alu: RTL and testbench
===============================

Name: seq_nbit_alu

Overview:
Registered, handshaked n-bit ALU. It keeps the existing 3-bit opcode map (MOV, NOT, ADD, SUB, OR, AND, SLT) and adds opcode 111 = MUL, a multi-cycle shift-add multiply with a 2n-bit product. It sits between the register-file read stage and writeback. Valid/ready handshakes on both sides let a multi-cycle op stall the producer, and a slow consumer can stall the ALU.

Parameters:
N, 8, operand/result width (N >= 2)
CNT_W, $clog2(N)+1, MUL iteration counter width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operands/opcode valid
in_ready  out  1  ALU can accept an operation this cycle
ALUOp  in  3  000 MOV, 001 NOT, 010 ADD, 011 SUB, 100 OR, 101 AND, 110 SLT, 111 MUL
R2  in  N  operand A
R3  in  N  operand B
out_valid  out  1  result registers hold a valid result
out_ready  in  1  consumer takes result
R1  out  N  result (MUL: low N bits of product)
R1_hi  out  N  MUL: high N bits of product; 0 for all other ops
c_out  out  1  ADD: carry out; SUB: 1 = no borrow (R2 >= R3 unsigned); 0 for all other ops
zero  out  1  R1 == 0 (MUL: whole 2N-bit product == 0)

Behaviour:
- Reset (rst_n low, async): state=IDLE; R1, R1_hi, c_out, zero, out_valid = 0; MUL counter and accumulators = 0. Deassertion takes effect on the next clk edge.
- Accept condition: in_valid && in_ready. Operands and opcode are captured at that edge. Inputs are ignored when not accepted.
- in_ready = (state==IDLE) || (state==DONE && out_ready). This allows back-to-back issue with no bubble.
- Single-cycle ops (000-110): result registered at the accept edge; state goes to DONE; out_valid=1 in the following cycle (latency 1).
- ADD: {c_out,R1} = R2+R3. SUB: R2 + ~R3 + 1, c_out = carry out of that sum. NOT: ~R2. MOV: R2.
- SLT: R1 = 1 if $signed(R2) < $signed(R3), else 0 (zero-extended to N bits). Overflow-correct: use the sign of the subtraction XOR signed overflow, not the raw sign bit.
- MUL (unsigned): the accept edge loads the multiplicand, multiplier and accumulator, clears the counter, and enters state MUL. Each cycle in MUL does one shift-add step. After N steps the state goes to DONE and out_valid=1. Latency from accept to out_valid = N+1 cycles. in_ready=0 throughout MUL.
- DONE: out_valid=1; R1, R1_hi, c_out, zero are held stable until the cycle out_ready=1.
  - out_ready && in_valid: accept the new op (goto MUL or stay DONE with new result).
  - out_ready && !in_valid: goto IDLE, out_valid=0. Result registers retain their last value.
- Outputs never change while out_valid=1 && out_ready=0. The bench asserts this.
- Opcode/operands changing on the inputs during MUL have no effect.
- Reset asserted mid-MUL: aborts immediately to IDLE with all outputs 0. No partial result is ever presented.
- States: IDLE -> (accept, op!=111) DONE; IDLE -> (accept, op==111) MUL; MUL -> (count==N-1) DONE; DONE -> as above.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams OP_MOV..OP_MUL (3-bit)
  - state encoding ST_IDLE/ST_MUL/ST_DONE (2-bit)
  - result/flag struct used by the writeback stage
- One sub-module: nbit_shift_add_mul. It holds the iterative datapath with ports start, busy, done, a, b, product[2N-1:0]. The top block contains the FSM, handshakes, single-cycle ops and output registers.

Test Plan:
1. N=8, ADD R2=200, R3=100, out_ready=1 -> next cycle out_valid=1, R1=0x2C, c_out=1, zero=0, R1_hi=0.
2. SUB 5-7 -> R1=0xFE, c_out=0. SUB 7-7 -> R1=0, c_out=1, zero=1. SLT 0x80 vs 0x01 -> R1=1. SLT 0x7F vs 0x80 -> R1=0.
3. MUL 0xFF*0xFF -> out_valid exactly 9 cycles after accept; R1=0x01, R1_hi=0xFE; in_ready=0 during cycles 1-8. MUL 0x00*0x37 -> zero=1.
4. Back-pressure: ADD 1+2 with out_ready=0 for 5 cycles while R2/R3/ALUOp toggle -> R1=3 held, in_ready=0. Raise out_ready with in_valid, OR 0xF0|0x0F -> next cycle R1=0xFF, no bubble.
5. Back-to-back stream of 7 single-cycle ops with out_ready=1 -> one result per cycle, in order, values checked against a reference model.
6. Assert rst_n low at cycle 4 of a MUL -> out_valid=0, R1=R1_hi=0 immediately. After release, AND 0xAA&0x0F -> R1=0x0A.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential n-bit ALU.
//   OP_*        : 3-bit opcode map presented on ALUOp
//   alu_state_t : controller state encoding (2-bit)
//   alu_flags_t : flag bundle handed to the writeback stage with R1/R1_hi
package alu_pkg;

    localparam logic [2:0] OP_MOV = 3'b000;
    localparam logic [2:0] OP_NOT = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_AND = 3'b101;
    localparam logic [2:0] OP_SLT = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DONE = 2'b10
    } alu_state_t;

    typedef struct packed {
        logic c_out;
        logic zero;
    } alu_flags_t;

    // Only MUL needs the iterative datapath; everything else completes
    // at the accept edge.
    function automatic logic is_multi_cycle(input logic [2:0] op);
        return (op == OP_MUL);
    endfunction

endpackage

// File: rtl/nbit_shift_add_mul.sv
// Iterative unsigned shift-add multiplier, one partial product per cycle.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   start      : load a/b and begin (ignored unless the controller is ready)
//   a, b       : multiplicand, multiplier
//   busy       : an operation is in progress
//   done       : high during the last step; product is valid in that cycle
//   product    : 2N-bit result of the step being taken (final when done=1)
module nbit_shift_add_mul #(
    parameter  int N     = 8,
    localparam int CNT_W = $clog2(N) + 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    logic [N-1:0]     mcand;
    logic [N-1:0]     acc_hi;
    logic [N-1:0]     acc_lo;
    logic [CNT_W-1:0] cnt;
    logic [N:0]       partial;
    logic [N-1:0]     step_hi;
    logic [N-1:0]     step_lo;

    // acc_lo starts as the multiplier and fills with product bits from the
    // top as the multiplier bits are shifted out of the bottom.
    always_comb begin
        partial = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
        step_hi = partial[N:1];
        step_lo = {partial[0], acc_lo[N-1:1]};
    end

    // Exposing the combinational step lets the controller capture the final
    // product on the same edge that retires the last step.
    assign done    = busy && (cnt == CNT_W'(N - 1));
    assign product = {step_hi, step_lo};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
        end else if (start) begin
            mcand  <= a;
            acc_hi <= '0;
            acc_lo <= b;
            cnt    <= '0;
            busy   <= 1'b1;
        end else if (busy) begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
            cnt    <= cnt + CNT_W'(1);
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/seq_nbit_alu.sv
// Registered, valid/ready handshaked n-bit ALU between register read and
// writeback. Single-cycle ops have latency 1; MUL has latency N+1.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   in_valid / in_ready : operation handshake (ALUOp, R2, R3)
//   out_valid/out_ready : result handshake (R1, R1_hi, c_out, zero)
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no result held; ready for a new operation
// ST_MUL  | iterative multiply running; input side stalled
// ST_DONE | result registers valid; held until the consumer takes them
module seq_nbit_alu
    import alu_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   ALUOp,
    input  logic [N-1:0] R2,
    input  logic [N-1:0] R3,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] R1,
    output logic [N-1:0] R1_hi,
    output logic         c_out,
    output logic         zero
);

    alu_state_t       state_q;
    alu_state_t       state_d;
    logic             accept;
    logic             mul_start;
    logic             mul_busy;
    logic             mul_done;
    logic [2*N-1:0]   mul_product;
    logic [N:0]       sum_add;
    logic [N:0]       sum_sub;
    logic             slt_ovf;
    logic             slt_lt;
    logic [N-1:0]     res_lo;
    logic             res_c;
    alu_flags_t       flags_q;

    assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && is_multi_cycle(ALUOp);
    assign out_valid = (state_q == ST_DONE);
    assign c_out     = flags_q.c_out;
    assign zero      = flags_q.zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = is_multi_cycle(ALUOp) ? ST_MUL : ST_DONE;
                end
            end
            ST_MUL: begin
                if (mul_done) begin
                    state_d = ST_DONE;
                end else if (!mul_busy) begin
                    // Datapath lost its operation; never present a partial result.
                    state_d = ST_IDLE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    if (in_valid) begin
                        state_d = is_multi_cycle(ALUOp) ? ST_MUL : ST_DONE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // SUB is R2 + ~R3 + 1, so its carry is the "no borrow" flag. SLT uses the
    // same difference; sign XOR overflow gives the true signed comparison.
    always_comb begin
        sum_add = {1'b0, R2} + {1'b0, R3};
        sum_sub = {1'b0, R2} + {1'b0, ~R3} + (N+1)'(1);
        slt_ovf = (R2[N-1] ^ R3[N-1]) & (sum_sub[N-1] ^ R2[N-1]);
        slt_lt  = sum_sub[N-1] ^ slt_ovf;
        res_lo  = '0;
        res_c   = 1'b0;
        case (ALUOp)
            OP_MOV: res_lo = R2;
            OP_NOT: res_lo = ~R2;
            OP_ADD: begin
                res_lo = sum_add[N-1:0];
                res_c  = sum_add[N];
            end
            OP_SUB: begin
                res_lo = sum_sub[N-1:0];
                res_c  = sum_sub[N];
            end
            OP_OR:  res_lo = R2 | R3;
            OP_AND: res_lo = R2 & R3;
            OP_SLT: res_lo = {{(N-1){1'b0}}, slt_lt};
            default: begin
                res_lo = '0;
                res_c  = 1'b0;
            end
        endcase
    end

    // Loads only on an accept (which needs out_ready when a result is held)
    // or on MUL completion, so outputs are stable while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            R1      <= '0;
            R1_hi   <= '0;
            flags_q <= '0;
        end else if (accept && !is_multi_cycle(ALUOp)) begin
            R1            <= res_lo;
            R1_hi         <= '0;
            flags_q.c_out <= res_c;
            flags_q.zero  <= (res_lo == '0);
        end else if ((state_q == ST_MUL) && mul_done) begin
            R1            <= mul_product[N-1:0];
            R1_hi         <= mul_product[2*N-1:N];
            flags_q.c_out <= 1'b0;
            flags_q.zero  <= (mul_product == '0);
        end
    end

    nbit_shift_add_mul #(
        .N (N)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (R2),
        .b       (R3),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

endmodule

// File: tb/tb_seq_nbit_alu.sv
module tb_seq_nbit_alu;

    localparam int N    = 8;
    localparam int MASK = (1 << N) - 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   ALUOp;
    logic [N-1:0] R2;
    logic [N-1:0] R3;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] R1;
    logic [N-1:0] R1_hi;
    logic         c_out;
    logic         zero;

    int errors = 0;
    int checks = 0;

    seq_nbit_alu #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ALUOp     (ALUOp),
        .R2        (R2),
        .R3        (R3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .R1        (R1),
        .R1_hi     (R1_hi),
        .c_out     (c_out),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        int r1;
        int hi;
        int c;
        int z;
    } res_t;

    typedef struct {
        logic [2:0] op;
        int a;
        int b;
        int r1;
        int hi;
        int c;
        int z;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model from the arithmetic definitions of each opcode.
    function automatic res_t model(input int op, input int a, input int b);
        res_t r;
        int sa, sb, p;
        r = '{0, 0, 0, 0};
        sa = (a >= (1 << (N-1))) ? a - (1 << N) : a;
        sb = (b >= (1 << (N-1))) ? b - (1 << N) : b;
        case (op)
            0: r.r1 = a;
            1: r.r1 = MASK - a;
            2: begin r.r1 = (a + b) & MASK; r.c = ((a + b) > MASK) ? 1 : 0; end
            3: begin r.r1 = (a - b) & MASK; r.c = (a >= b) ? 1 : 0; end
            4: r.r1 = a | b;
            5: r.r1 = a & b;
            6: r.r1 = (sa < sb) ? 1 : 0;
            default: begin
                p = a * b;
                r.r1 = p & MASK;
                r.hi = (p >> N) & MASK;
            end
        endcase
        if (op == 7) r.z = ((a * b) == 0) ? 1 : 0;
        else         r.z = (r.r1 == 0) ? 1 : 0;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input int a, input int b);
        int guard = 0;
        while (!in_ready && guard < 50) begin
            step();
            guard++;
        end
        check("issue_in_ready", int'(in_ready), 1);
        in_valid = 1'b1;
        ALUOp    = op;
        R2       = a[N-1:0];
        R3       = b[N-1:0];
        step();
        in_valid = 1'b0;
    endtask

    // Called right after the accept edge; counts cycles until out_valid.
    task automatic wait_result(input int exp_lat);
        int lat = 1;
        while (!out_valid && lat < 40) begin
            check("busy_in_ready", int'(in_ready), 0);
            step();
            lat++;
        end
        check("latency", lat, exp_lat);
    endtask

    task automatic check_outputs(input string tag, input res_t e);
        check({tag, "_valid"}, int'(out_valid), 1);
        check({tag, "_r1"},    int'(R1),        e.r1);
        check({tag, "_r1_hi"}, int'(R1_hi),     e.hi);
        check({tag, "_c_out"}, int'(c_out),     e.c);
        check({tag, "_zero"},  int'(zero),      e.z);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        step();
    endtask

    // Held-output monitor: a stalled result must not move on the next edge.
    logic         stall_prev = 1'b0;
    logic [N-1:0] r1_prev, hi_prev;
    logic         c_prev, z_prev;
    always @(negedge clk) begin
        if (rst_n && stall_prev) begin
            check("hold_valid", int'(out_valid), 1);
            check("hold_r1",    int'(R1),        int'(r1_prev));
            check("hold_r1_hi", int'(R1_hi),     int'(hi_prev));
            check("hold_flags", int'({c_out, zero}), int'({c_prev, z_prev}));
        end
        stall_prev = rst_n && out_valid && !out_ready;
        r1_prev = R1;
        hi_prev = R1_hi;
        c_prev  = c_out;
        z_prev  = zero;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        res_t e;
        int   op, a, b, k;

        vecs[0]  = '{3'b010, 200,  100,  'h2C, 0,    1, 0};
        vecs[1]  = '{3'b011, 5,    7,    'hFE, 0,    0, 0};
        vecs[2]  = '{3'b011, 7,    7,    0,    0,    1, 1};
        vecs[3]  = '{3'b110, 'h80, 'h01, 1,    0,    0, 0};
        vecs[4]  = '{3'b110, 'h7F, 'h80, 0,    0,    0, 1};
        vecs[5]  = '{3'b111, 'hFF, 'hFF, 'h01, 'hFE, 0, 0};
        vecs[6]  = '{3'b111, 'h00, 'h37, 0,    0,    0, 1};
        vecs[7]  = '{3'b000, 'h5A, 'h33, 'h5A, 0,    0, 0};
        vecs[8]  = '{3'b001, 'h0F, 'h00, 'hF0, 0,    0, 0};
        vecs[9]  = '{3'b100, 'hF0, 'h0F, 'hFF, 0,    0, 0};
        vecs[10] = '{3'b101, 'hAA, 'h0F, 'h0A, 0,    0, 0};
        vecs[11] = '{3'b010, 'hFF, 'h01, 0,    0,    1, 1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        ALUOp     = 3'b000;
        R2        = '0;
        R3        = '0;
        #12;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_r1",        int'(R1),        0);
        check("rst_r1_hi",     int'(R1_hi),     0);
        check("rst_c_out",     int'(c_out),     0);
        check("rst_zero",      int'(zero),      0);
        check("rst_in_ready",  int'(in_ready),  1);
        rst_n = 1'b1;
        step();

        // Directed vector table
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_result((vecs[i].op == 3'b111) ? N + 1 : 1);
            check_outputs($sformatf("vec%0d", i),
                          '{vecs[i].r1, vecs[i].hi, vecs[i].c, vecs[i].z});
        end

        // Back-pressure: ADD held while inputs churn, then OR with no bubble
        drain();
        out_ready = 1'b0;
        issue(3'b010, 1, 2);
        check("bp_first_r1", int'(R1), 3);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            ALUOp    = 3'($urandom_range(0, 7));
            R2       = N'($urandom);
            R3       = N'($urandom);
            step();
            check("bp_hold_r1",    int'(R1),        3);
            check("bp_in_ready",   int'(in_ready),  0);
            check("bp_out_valid",  int'(out_valid), 1);
        end
        in_valid  = 1'b1;
        ALUOp     = 3'b100;
        R2        = 8'hF0;
        R3        = 8'h0F;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("bp_next_valid", int'(out_valid), 1);
        check("bp_next_r1",    int'(R1),        'hFF);

        // Back-to-back stream of single-cycle ops, one result per cycle
        drain();
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            a = int'($urandom_range(0, MASK));
            b = int'($urandom_range(0, MASK));
            in_valid = 1'b1;
            ALUOp    = 3'(i);
            R2       = a[N-1:0];
            R3       = b[N-1:0];
            step();
            check_outputs($sformatf("stream%0d", i), model(i, a, b));
        end
        in_valid = 1'b0;

        // Randomized ops (MUL included) with random consumer stalls
        drain();
        for (int i = 0; i < 25; i++) begin
            op = int'($urandom_range(0, 7));
            a  = int'($urandom_range(0, MASK));
            b  = int'($urandom_range(0, MASK));
            e  = model(op, a, b);
            out_ready = 1'b0;
            issue(3'(op), a, b);
            wait_result((op == 7) ? N + 1 : 1);
            check_outputs($sformatf("rand%0d", i), e);
            k = int'($urandom_range(0, 3));
            for (int j = 0; j < k; j++) begin
                ALUOp    = 3'($urandom_range(0, 7));
                R2       = N'($urandom);
                in_valid = 1'($urandom_range(0, 1));
                step();
                check("rand_stall_r1", int'(R1), e.r1);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            step();
            check("rand_released", int'(out_valid), 0);
        end

        // Reset during MUL, then recovery
        drain();
        issue(3'b000, 'h5A, 0);
        check("pre_rst_r1", int'(R1), 'h5A);
        issue(3'b111, 'hFF, 'hFF);
        step();
        step();
        step();
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_r1",        int'(R1),        0);
        check("midrst_r1_hi",     int'(R1_hi),     0);
        check("midrst_flags",     int'({c_out, zero}), 0);
        step();
        check("midrst_held", int'(out_valid), 0);
        rst_n = 1'b1;
        step();
        check("post_rst_idle", int'(out_valid), 0);
        issue(3'b101, 'hAA, 'h0F);
        wait_result(1);
        check_outputs("post_rst_and", '{'h0A, 0, 0, 0});
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
